// File: rtl/count_monitor.sv
// count_monitor: wrap-extended counter monitor with compare pulse and handshaked timestamp capture
module count_monitor #(
  parameter int CNT_W = 8,
  parameter int EXT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [CNT_W-1:0]       cnt_in,
  input  logic [CNT_W-1:0]       cmp_val,
  input  logic                   clr,
  input  logic                   cap_req,
  input  logic                   cap_ready,
  output logic                   wrap_pulse,
  output logic                   match_pulse,
  output logic [EXT_W-1:0]       ext_cnt,
  output logic                   ovf,
  output logic [EXT_W+CNT_W-1:0] cap_data,
  output logic                   cap_valid,
  output logic                   cap_drop
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q;
  logic                     primed_q;
  logic                     wrap_q, wrap_d;
  logic                     match_q, match_d;
  logic [EXT_W-1:0]         ext_q, ext_d, ext_w;
  logic                     ovf_q, ovf_d;
  logic [EXT_W+CNT_W-1:0]   cap_data_q, cap_data_d;
  logic                     cap_drop_q, cap_drop_d;
  logic                     ext_sat, load, drop;
  // next-state: wrap/match detection, saturating extension, capture handshake
  always_comb begin
    wrap_d     = primed_q && cnt_q == '1 && cnt_in == '0;
    match_d    = primed_q && cnt_in == cmp_val && cnt_q != cnt_in;
    ext_sat    = ext_q == '1;
    ext_w      = (wrap_d && !ext_sat) ? ext_q + 1'b1 : ext_q;
    ext_d      = clr ? '0 : ext_w;
    ovf_d      = clr ? 1'b0 : ovf_q | (wrap_d & ext_sat);
    load       = cap_req && (state_q == IDLE || cap_ready);
    drop       = cap_req && state_q == HOLD && !cap_ready;
    cap_drop_d = clr ? 1'b0 : cap_drop_q | drop;
    cap_data_d = load ? {ext_w, cnt_in} : cap_data_q;
    state_d    = load ? HOLD : (state_q == HOLD && cap_ready) ? IDLE : state_q;
  end
  // all state registered; async reset discards any pending capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      primed_q   <= 1'b0;
      wrap_q     <= 1'b0;
      match_q    <= 1'b0;
      ext_q      <= '0;
      ovf_q      <= 1'b0;
      cap_data_q <= '0;
      cap_drop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_in;
      primed_q   <= 1'b1;
      wrap_q     <= wrap_d;
      match_q    <= match_d;
      ext_q      <= ext_d;
      ovf_q      <= ovf_d;
      cap_data_q <= cap_data_d;
      cap_drop_q <= cap_drop_d;
    end
  end
  assign wrap_pulse  = wrap_q;
  assign match_pulse = match_q;
  assign ext_cnt     = ext_q;
  assign ovf         = ovf_q;
  assign cap_data    = cap_data_q;
  assign cap_valid   = state_q == HOLD;
  assign cap_drop    = cap_drop_q;
endmodule

// File: tb/tb_count_monitor.sv
// tb_count_monitor: directed self-checking bench for count_monitor
module tb_count_monitor;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  cnt_in = 8'h00;
  logic [7:0]  cmp_val = 8'h00;
  logic        clr = 1'b0;
  logic        cap_req = 1'b0;
  logic        cap_ready = 1'b0;
  logic        wrap_pulse, match_pulse, ovf, cap_valid, cap_drop;
  logic [7:0]  ext_cnt;
  logic [15:0] cap_data;
  int          checks = 0;
  int          errors = 0;

  count_monitor dut (
    .clk(clk), .reset_n(reset_n), .cnt_in(cnt_in), .cmp_val(cmp_val), .clr(clr),
    .cap_req(cap_req), .cap_ready(cap_ready), .wrap_pulse(wrap_pulse),
    .match_pulse(match_pulse), .ext_cnt(ext_cnt), .ovf(ovf), .cap_data(cap_data),
    .cap_valid(cap_valid), .cap_drop(cap_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".wrap"}, {15'd0, wrap_pulse}, 16'h0);
    chk({tag, ".match"}, {15'd0, match_pulse}, 16'h0);
    chk({tag, ".ext"}, {8'd0, ext_cnt}, 16'h0);
    chk({tag, ".ovf"}, {15'd0, ovf}, 16'h0);
    chk({tag, ".data"}, cap_data, 16'h0);
    chk({tag, ".valid"}, {15'd0, cap_valid}, 16'h0);
    chk({tag, ".drop"}, {15'd0, cap_drop}, 16'h0);
  endtask

  initial begin
    // 1: reset with cnt==cmp, release -> no match on first sample
    cnt_in = 8'h05; cmp_val = 8'h05;
    #12;
    chk_all_zero("rst");
    reset_n = 1'b1;
    step();
    chk_all_zero("first");
    step();
    chk("hold5.match", {15'd0, match_pulse}, 16'h0);
    // 2: sweep across a wrap
    cmp_val = 8'h80;
    cnt_in = 8'hFE; step(); chk("fe.wrap", {15'd0, wrap_pulse}, 16'h0);
    cnt_in = 8'hFF; step(); chk("ff.wrap", {15'd0, wrap_pulse}, 16'h0);
    cnt_in = 8'h00; step(); chk("00.wrap", {15'd0, wrap_pulse}, 16'h1);
    chk("00.ext", {8'd0, ext_cnt}, 16'h1);
    cnt_in = 8'h01; step(); chk("01.wrap", {15'd0, wrap_pulse}, 16'h0);
    chk("01.ext", {8'd0, ext_cnt}, 16'h1);
    for (int i = 0; i < 254; i++) begin
      cnt_in = 8'hFF; step();
      cnt_in = 8'h00; step();
    end
    chk("sat.ext", {8'd0, ext_cnt}, 16'h00FF);
    chk("sat.ovf", {15'd0, ovf}, 16'h0);
    cnt_in = 8'hFF; step();
    cnt_in = 8'h00; step();
    chk("ovf.ext", {8'd0, ext_cnt}, 16'h00FF);
    chk("ovf.ovf", {15'd0, ovf}, 16'h1);
    chk("ovf.wrap", {15'd0, wrap_pulse}, 16'h1);
    // 3: clr, then counter reset 7E->42 is a match but not a wrap
    clr = 1'b1; cnt_in = 8'h7E; step(); clr = 1'b0;
    chk("clr.ext", {8'd0, ext_cnt}, 16'h0);
    chk("clr.ovf", {15'd0, ovf}, 16'h0);
    cmp_val = 8'h42; cnt_in = 8'h42; step();
    chk("42.wrap", {15'd0, wrap_pulse}, 16'h0);
    chk("42.match", {15'd0, match_pulse}, 16'h1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("42hold.match", {15'd0, match_pulse}, 16'h0);
    end
    cmp_val = 8'h50; step();
    cmp_val = 8'h42; step();
    chk("cmpchg.match", {15'd0, match_pulse}, 16'h0);
    // 4: capture with ext=3
    for (int i = 0; i < 3; i++) begin
      cnt_in = 8'hFF; step();
      cnt_in = 8'h00; step();
    end
    chk("ext3", {8'd0, ext_cnt}, 16'h3);
    cnt_in = 8'h10; cap_req = 1'b1; step(); cap_req = 1'b0;
    chk("cap.valid", {15'd0, cap_valid}, 16'h1);
    chk("cap.data", cap_data, 16'h0310);
    for (int i = 0; i < 4; i++) begin
      cnt_in = cnt_in + 8'h1; step();
      chk("stall.valid", {15'd0, cap_valid}, 16'h1);
      chk("stall.data", cap_data, 16'h0310);
    end
    cap_ready = 1'b1; step(); cap_ready = 1'b0;
    chk("acc.valid", {15'd0, cap_valid}, 16'h0);
    // 5: capture then drop while stalled, then clr
    cnt_in = 8'h20; cap_req = 1'b1; step();
    chk("cap2.data", cap_data, 16'h0320);
    cnt_in = 8'h21; step(); cap_req = 1'b0;
    chk("drop.drop", {15'd0, cap_drop}, 16'h1);
    chk("drop.data", cap_data, 16'h0320);
    chk("drop.valid", {15'd0, cap_valid}, 16'h1);
    clr = 1'b1; step(); clr = 1'b0;
    chk("clr2.drop", {15'd0, cap_drop}, 16'h0);
    chk("clr2.ext", {8'd0, ext_cnt}, 16'h0);
    chk("clr2.valid", {15'd0, cap_valid}, 16'h1);
    cnt_in = 8'h30; cap_req = 1'b1; cap_ready = 1'b1; step(); cap_req = 1'b0; cap_ready = 1'b0;
    chk("reload.valid", {15'd0, cap_valid}, 16'h1);
    chk("reload.data", cap_data, 16'h0030);
    chk("reload.drop", {15'd0, cap_drop}, 16'h0);
    // 6: clr on the wrap edge, capture sees the increment; then async reset in HOLD
    cnt_in = 8'hFF; step();
    cnt_in = 8'h00; clr = 1'b1; cap_req = 1'b1; cap_ready = 1'b1; step();
    clr = 1'b0; cap_req = 1'b0; cap_ready = 1'b0;
    chk("clrwrap.ext", {8'd0, ext_cnt}, 16'h0);
    chk("clrwrap.wrap", {15'd0, wrap_pulse}, 16'h1);
    chk("clrwrap.ovf", {15'd0, ovf}, 16'h0);
    chk("clrwrap.data", cap_data, 16'h0100);
    chk("clrwrap.valid", {15'd0, cap_valid}, 16'h1);
    #2 reset_n = 1'b0;
    #1;
    chk_all_zero("async");
    #3 reset_n = 1'b1;
    step();
    chk("post.valid", {15'd0, cap_valid}, 16'h0);
    chk("post.ext", {8'd0, ext_cnt}, 16'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
